// File: rtl/alu_pkg.sv
// Shared constants for the sequential divider: FSM encoding, default
// widths and the quotient reported on a divide-by-zero.
package alu_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Quotient reported when the divisor is zero (all ones at the default width).
  localparam logic [DW_DEF-1:0] DZ_QUOT = 8'hFF;

endpackage

// File: rtl/alu_divider_seq_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if the result does not borrow.
module alu_divider_seq_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   p_i,
  input  logic          bit_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   p_o,
  output logic          qbit_o
);

  localparam int PW = VW + 1;
  localparam int TW = VW + 2;

  logic [TW-1:0] t_s;
  logic [TW:0]   diff_s;
  logic          borrow_s;

  // Trial subtract one bit wider than the shifted remainder; the top bit is the borrow.
  always_comb begin
    t_s      = {p_i, bit_i};
    diff_s   = {1'b0, t_s} - {3'b000, dvs_i};
    borrow_s = diff_s[TW];
    qbit_o   = ~borrow_s;
    if (borrow_s) begin
      p_o = PW'(t_s);
    end else begin
      p_o = PW'(diff_s);
    end
  end

endmodule

// File: rtl/alu_divider_seq.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, start/busy/done handshake, DZ on zero divisor.
module alu_divider_seq
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [DW-1:0] A,
  input  logic [VW-1:0] B,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          DZ
);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   p_q, p_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [VW:0]   p_nxt_s;
  logic          qbit_s;
  logic [DW-1:0] quo_sh_s;

  alu_divider_seq_div_step #(.VW(VW)) u_div_step (
    .p_i    (p_q),
    .bit_i  (dvd_q[DW-1]),
    .dvs_i  (dvs_q),
    .p_o    (p_nxt_s),
    .qbit_o (qbit_s)
  );

  // Quotient register with the fresh quotient bit appended at the LSB.
  always_comb begin
    quo_sh_s = (quo_q << 1'b1) | {{(DW-1){1'b0}}, qbit_s};
  end

  // Next-state logic. A zero divisor spends one non-iterating cycle in RUN
  // (marked by dz_q) so that DONE appears one edge after the accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          dvd_d   = A;
          dvs_d   = B;
          p_d     = {(VW+1){1'b0}};
          cnt_d   = {CW{1'b0}};
          quo_d   = {DW{1'b0}};
          if (B == {VW{1'b0}}) begin
            q_d  = DZ_QUOT;
            r_d  = {VW{1'b0}};
            dz_d = 1'b1;
          end else begin
            dz_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (dz_q) begin
          state_d = ST_FIN;
        end else begin
          dvd_d = dvd_q << 1'b1;
          p_d   = p_nxt_s;
          quo_d = quo_sh_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(DW - 1)) begin
            state_d = ST_FIN;
            q_d     = quo_sh_s;
            r_d     = p_nxt_s[VW-1:0];
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      dvd_q   <= {DW{1'b0}};
      dvs_q   <= {VW{1'b0}};
      p_q     <= {(VW+1){1'b0}};
      quo_q   <= {DW{1'b0}};
      q_q     <= {DW{1'b0}};
      r_q     <= {VW{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DZ   = dz_q;

endmodule

// File: tb/tb_alu_divider_seq.sv
// Scoreboard bench for alu_divider_seq: stimulus pushes expected results
// computed with plain integer division; a monitor checks every DONE pulse.
module tb_alu_divider_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic [7:0] A;
  logic [3:0] B;
  logic       BUSY, DONE, DZ;
  logic [7:0] Q;
  logic [3:0] R;

  alu_divider_seq dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DZ(DZ)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  bit   stab_en = 1'b0;
  bit   have_last = 1'b0;
  bit   chk_busy_next = 1'b0;
  logic [7:0] last_q;
  logic [3:0] last_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all ones / 0 / DZ.
  function automatic exp_t model(input logic [7:0] a, input logic [3:0] b, input int k);
    exp_t x;
    x.a = a;
    x.b = b;
    if (b == 4'd0) begin
      x.q = 8'hFF; x.r = 4'd0; x.dz = 1'b1; x.done_cyc = k + 1;
    end else begin
      x.q = 8'(int'(a) / int'(b));
      x.r = 4'(int'(a) % int'(b));
      x.dz = 1'b0;
      x.done_cyc = k + 8;
    end
    return x;
  endfunction

  // Monitor: compare every DONE against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (chk_busy_next) begin
        chk("busy_after_done", BUSY, 0);
        chk_busy_next = 1'b0;
      end
      if (DONE === 1'b1) begin
        n_done++;
        chk("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("quotient", Q, e.q);
          chk("remainder", R, e.r);
          chk("dz_flag", DZ, e.dz);
          chk("done_latency", cyc, e.done_cyc);
          chk("busy_in_fin", BUSY, 1);
          if (!e.dz) begin
            chk("invariant_a_eq_qb_r", int'(Q) * int'(e.b) + int'(R), int'(e.a));
            chk("invariant_r_lt_b", int'(R) < int'(e.b), 1);
          end
        end
        last_q = Q;
        last_r = R;
        have_last = 1'b1;
        chk_busy_next = 1'b1;
      end else if (stab_en && have_last) begin
        chk("q_stable", Q, last_q);
        chk("r_stable", R, last_r);
      end
    end
  end

  // Caller is at a negedge; START is sampled on the following posedge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    START = 1'b1;
    A = a;
    B = b;
    exp_q.push_back(model(a, b, cyc + 1));
    @(negedge CLK);
    START = 1'b0;
    A = 8'($urandom);
    B = 4'($urandom);
    chk("busy_after_start", BUSY, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_within_bound", n < 40, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int wt;
    int pairs[$];
    RST_N = 1'b0; START = 1'b0; A = 8'd0; B = 4'd0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_q", Q, 0);
    chk("reset_r", R, 0);
    chk("reset_dz", DZ, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Basic and boundary divisions.
    issue(8'd200, 4'd7);  wait_idle();
    issue(8'd255, 4'd1);  wait_idle();
    issue(8'd255, 4'd15); wait_idle();
    issue(8'd0,   4'd5);  wait_idle();
    issue(8'd14,  4'd15); wait_idle();

    // Divide by zero, then a normal op clears DZ.
    issue(8'd77, 4'd0); wait_idle();
    issue(8'd9,  4'd3); wait_idle();

    // START while busy (during RUN and during FIN) is ignored.
    nd = n_done;
    issue(8'd100, 4'd9);
    @(negedge CLK);
    START = 1'b1; A = 8'd50; B = 4'd2;
    @(negedge CLK);
    START = 1'b0;
    wt = 0;
    while (DONE !== 1'b1 && wt < 20) begin
      @(negedge CLK);
      wt++;
    end
    chk("done_seen_busy_test", wt < 20, 1);
    START = 1'b1; A = 8'd50; B = 4'd2;
    @(negedge CLK);
    START = 1'b0;
    repeat (12) @(negedge CLK);
    chk("single_done_busy_test", n_done - nd, 1);

    // Reset in the middle of RUN.
    issue(8'd123, 4'd5);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midreset_busy", BUSY, 0);
    chk("midreset_done", DONE, 0);
    chk("midreset_q", Q, 0);
    chk("midreset_r", R, 0);
    chk("midreset_dz", DZ, 0);
    exp_q.delete();
    chk_busy_next = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    nd = n_done;
    repeat (15) @(negedge CLK);
    chk("no_done_after_reset", n_done - nd, 0);
    issue(8'd60, 4'd4); wait_idle();

    // Shuffled sweep of every dividend with every nonzero divisor, back to back.
    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        pairs.push_back(a * 16 + b);
    for (int i = pairs.size() - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(i, 0);
      t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
    end
    stab_en = 1'b1;
    foreach (pairs[i]) begin
      issue(8'(pairs[i] / 16), 4'(pairs[i] % 16));
      wait_idle();
    end
    stab_en = 1'b0;

    @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
